// File: rtl/button_conditioner_if.sv
// Button pin and conditioned-event bundle shared by the conditioner and its consumers.
// The master side drives the raw pins; the slave side returns level and event pulses.
interface button_conditioner_if #(
  parameter int N_BTN = 4
) ();
  logic [N_BTN-1:0] BtnRaw;
  logic [N_BTN-1:0] BtnLevel;
  logic [N_BTN-1:0] BtnPress;
  logic [N_BTN-1:0] BtnRelease;
  logic [N_BTN-1:0] BtnHold;

  modport master (
    output BtnRaw,
    input  BtnLevel,
    input  BtnPress,
    input  BtnRelease,
    input  BtnHold
  );

  modport slave (
    input  BtnRaw,
    output BtnLevel,
    output BtnPress,
    output BtnRelease,
    output BtnHold
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, stability-count debouncer, press/release edge pulses and
// a single long-press pulse. Every button is an independent copy of the same slice.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int HOLD_W          = 27
) (
  input logic                  Clk,
  input logic                  nReset,
  button_conditioner_if.slave  btn
);

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;
  logic [N_BTN-1:0] hold_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic              s1_reg;
      logic              s2_reg;
      logic              level_reg;
      logic              press_reg;
      logic              release_reg;
      logic              hold_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [HOLD_W-1:0] hcnt_reg;
      logic              accept;
      logic              falling;

      // The synchronised input has disagreed with the level for the full window.
      assign accept  = (s2_reg != level_reg) && (cnt_reg == DB_LAST);
      assign falling = accept && !s2_reg;

      always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
          s1_reg      <= 1'b0;
          s2_reg      <= 1'b0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          hold_reg    <= 1'b0;
          cnt_reg     <= '0;
          hcnt_reg    <= '0;
        end else begin
          s1_reg      <= btn.BtnRaw[gi];
          s2_reg      <= s1_reg;
          press_reg   <= accept && s2_reg;
          release_reg <= falling;
          hold_reg    <= 1'b0;

          if (s2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (accept) begin
            level_reg <= s2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end

          // A release on this edge wins over a hold that would complete on it.
          if (!level_reg || falling) begin
            hcnt_reg <= '0;
          end else if (hcnt_reg == HOLD_LAST) begin
            hold_reg <= 1'b1;
            hcnt_reg <= HOLD_SAT;
          end else if (hcnt_reg != HOLD_SAT) begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end
      end

      assign level_vec[gi]   = level_reg;
      assign press_vec[gi]   = press_reg;
      assign release_vec[gi] = release_reg;
      assign hold_vec[gi]    = hold_reg;
    end
  endgenerate

  assign btn.BtnLevel   = level_vec;
  assign btn.BtnPress   = press_vec;
  assign btn.BtnRelease = release_vec;
  assign btn.BtnHold    = hold_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with two buttons, an 8-cycle debounce window and a 32-cycle hold.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DC = 8;
  localparam int HC = 32;

  logic Clk;
  logic nReset;

  button_conditioner_if #(.N_BTN(NB)) bus ();

  button_conditioner #(
    .N_BTN(NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(4),
    .HOLD_CYCLES(HC),
    .HOLD_W(6)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .btn(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        nrst;
    logic [1:0]  raw;
    int          ticks;
    logic [1:0]  lvl;
    logic [1:0]  prs;
    logic [1:0]  rel;
    logic [1:0]  hld;
  } vec_t;

  vec_t vecs[10];

  int checks;
  int errors;
  int edge_no;
  int prs_cnt[NB], rel_cnt[NB], hld_cnt[NB];
  int prs_edge[NB], rel_edge[NB], hld_edge[NB];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    for (int b = 0; b < NB; b++) begin
      prs_cnt[b] = 0; rel_cnt[b] = 0; hld_cnt[b] = 0;
      prs_edge[b] = -1; rel_edge[b] = -1; hld_edge[b] = -1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    edge_no++;
    #1;
    for (int b = 0; b < NB; b++) begin
      if (bus.BtnPress[b])   begin prs_cnt[b]++; prs_edge[b] = edge_no; end
      if (bus.BtnRelease[b]) begin rel_cnt[b]++; rel_edge[b] = edge_no; end
      if (bus.BtnHold[b])    begin hld_cnt[b]++; hld_edge[b] = edge_no; end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                            input logic [1:0] rel, input logic [1:0] hld);
    check({tag, "_level"},   int'(bus.BtnLevel),   int'(lvl));
    check({tag, "_press"},   int'(bus.BtnPress),   int'(prs));
    check({tag, "_release"}, int'(bus.BtnRelease), int'(rel));
    check({tag, "_hold"},    int'(bus.BtnHold),    int'(hld));
  endtask

  int k, kr, r;

  initial begin
    checks  = 0;
    errors  = 0;
    edge_no = 0;
    nReset  = 1'b0;
    bus.BtnRaw = 2'b00;
    clear_rec();
    ticks(2);

    // Reset with held buttons, deassert, release, then a 7-cycle glitch.
    vecs[0] = '{1'b0, 2'b11, 0,  2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1] = '{1'b0, 2'b11, 3,  2'b00, 2'b00, 2'b00, 2'b00};
    vecs[2] = '{1'b1, 2'b11, 9,  2'b00, 2'b00, 2'b00, 2'b00};
    vecs[3] = '{1'b1, 2'b11, 1,  2'b11, 2'b11, 2'b00, 2'b00};
    vecs[4] = '{1'b1, 2'b11, 1,  2'b11, 2'b00, 2'b00, 2'b00};
    vecs[5] = '{1'b1, 2'b00, 9,  2'b11, 2'b00, 2'b00, 2'b00};
    vecs[6] = '{1'b1, 2'b00, 1,  2'b00, 2'b00, 2'b11, 2'b00};
    vecs[7] = '{1'b1, 2'b00, 1,  2'b00, 2'b00, 2'b00, 2'b00};
    vecs[8] = '{1'b1, 2'b01, 7,  2'b00, 2'b00, 2'b00, 2'b00};
    vecs[9] = '{1'b1, 2'b00, 12, 2'b00, 2'b00, 2'b00, 2'b00};

    clear_rec();
    for (int i = 0; i < 10; i++) begin
      nReset     = vecs[i].nrst;
      bus.BtnRaw = vecs[i].raw;
      if (vecs[i].ticks == 0) #1;
      else ticks(vecs[i].ticks);
      check_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].hld);
    end
    for (int b = 0; b < NB; b++) begin
      check($sformatf("table_press_count%0d", b),   prs_cnt[b], 1);
      check($sformatf("table_release_count%0d", b), rel_cnt[b], 1);
      check($sformatf("table_hold_count%0d", b),    hld_cnt[b], 0);
    end
    $display("table vectors applied: %0d checks so far", checks);

    // Bounce then stable.
    clear_rec();
    for (int i = 0; i < 40; i++) begin
      bus.BtnRaw = (((i / 3) % 2) == 0) ? 2'b01 : 2'b00;
      tick();
    end
    check("bounce_press_count",   prs_cnt[0], 0);
    check("bounce_release_count", rel_cnt[0], 0);
    check("bounce_level",         int'(bus.BtnLevel), 0);
    bus.BtnRaw = 2'b01;
    k = edge_no + 1;
    ticks(20);
    check("bounce_final_press_count", prs_cnt[0], 1);
    check("bounce_final_press_edge",  prs_edge[0], k + 9);
    check("bounce_final_level",       int'(bus.BtnLevel), 1);
    $display("bounce then stable: press at edge %0d", prs_edge[0]);
    bus.BtnRaw = 2'b00;
    ticks(12);

    // Long press with one hold pulse, then release after saturation.
    clear_rec();
    bus.BtnRaw = 2'b01;
    k = edge_no + 1;
    r = k + 9;
    ticks(60);
    check("long_press_edge",  prs_edge[0], r);
    check("long_press_count", prs_cnt[0], 1);
    check("long_hold_count",  hld_cnt[0], 1);
    check("long_hold_edge",   hld_edge[0], r + HC);
    bus.BtnRaw = 2'b00;
    kr = edge_no + 1;
    ticks(12);
    check("long_release_count", rel_cnt[0], 1);
    check("long_release_edge",  rel_edge[0], kr + 9);
    check("long_hold_no_repeat", hld_cnt[0], 1);
    check("long_level_after", int'(bus.BtnLevel), 0);
    $display("long press: press %0d hold %0d release %0d", prs_edge[0], hld_edge[0], rel_edge[0]);

    // Short presses on both buttons, three cycles apart.
    clear_rec();
    bus.BtnRaw = 2'b01;
    k = edge_no + 1;
    ticks(3);
    bus.BtnRaw = 2'b11;
    ticks(17);
    bus.BtnRaw = 2'b10;
    ticks(3);
    bus.BtnRaw = 2'b00;
    ticks(15);
    check("short_press_edge0",   prs_edge[0], k + 9);
    check("short_press_edge1",   prs_edge[1], k + 12);
    check("short_release_edge0", rel_edge[0], k + 29);
    check("short_release_edge1", rel_edge[1], k + 32);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("short_press_count%0d", b),   prs_cnt[b], 1);
      check($sformatf("short_release_count%0d", b), rel_cnt[b], 1);
      check($sformatf("short_hold_count%0d", b),    hld_cnt[b], 0);
    end
    $display("short presses: press %0d/%0d release %0d/%0d",
             prs_edge[0], prs_edge[1], rel_edge[0], rel_edge[1]);

    // Reset mid-operation: button 0 at hold count 20, button 1 at debounce count 5.
    clear_rec();
    bus.BtnRaw = 2'b01;
    ticks(23);
    bus.BtnRaw = 2'b11;
    ticks(7);
    check("midreset_level_before", int'(bus.BtnLevel), 1);
    nReset = 1'b0;
    #1;
    check_outs("midreset_async", 2'b00, 2'b00, 2'b00, 2'b00);
    clear_rec();
    ticks(3);
    check("midreset_no_pulse_press",   prs_cnt[0] + prs_cnt[1], 0);
    check("midreset_no_pulse_release", rel_cnt[0] + rel_cnt[1], 0);
    check("midreset_no_pulse_hold",    hld_cnt[0] + hld_cnt[1], 0);
    nReset = 1'b1;
    k = edge_no + 1;
    ticks(45);
    for (int b = 0; b < NB; b++) begin
      check($sformatf("midreset_press_edge%0d", b),   prs_edge[b], k + 9);
      check($sformatf("midreset_press_count%0d", b),  prs_cnt[b], 1);
      check($sformatf("midreset_hold_edge%0d", b),    hld_edge[b], k + 9 + HC);
      check($sformatf("midreset_hold_count%0d", b),   hld_cnt[b], 1);
      check($sformatf("midreset_release_count%0d", b), rel_cnt[b], 0);
    end
    $display("mid-operation reset: press %0d hold %0d", prs_edge[0], hld_edge[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
